// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC generation, 1-cycle synchronous imem port,
// and a credit-controlled prefetch FIFO with valid/ready handshake to decode.
module fetch_queue_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              ROM_ADDR_W = 10,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ROM_ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_inst,
    output logic [XLEN-1:0]       out_pc,
    output logic                  err_misaligned
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0]  inflight_pc_reg;
    logic             inflight_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic             err_reg;

    logic [XLEN-1:0]  inst_mem [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic [CNT_W:0]   credit_used;

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;
    // A response that lands during a redirect belongs to the abandoned path.
    assign push      = inflight_reg & ~redirect_valid;

    // Queued entries plus the outstanding read must fit; a same-cycle pop frees a slot.
    assign credit_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg}
                       - {{CNT_W{1'b0}}, pop};
    assign imem_req    = ~rst & ~redirect_valid
                       & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc_reg[ROM_ADDR_W+1:2];

    // Head is forced to zero while empty so the outputs are clean out of reset.
    assign out_inst       = out_valid ? inst_mem[rd_ptr_reg] : '0;
    assign out_pc         = out_valid ? pc_mem[rd_ptr_reg]   : '0;
    assign err_misaligned = err_reg;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        if (redirect_valid) begin
            fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(4);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            err_reg         <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            inflight_reg <= imem_req;
            if (imem_req) begin
                inflight_pc_reg <= fetch_pc_reg;
            end
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: vector table for streaming/redirects,
// hand sequences for backpressure, async reset and PC wrap-around.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        rst = 1'b1;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        err_misaligned;

    // Second DUT for PC wrap-around
    logic        rst2 = 1'b1;
    logic        imem_req2;
    logic [9:0]  imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] out_inst2;
    logic [31:0] out_pc2;
    logic        err_misaligned2;

    fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .ROM_ADDR_W(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .err_misaligned(err_misaligned)
    );

    fetch_queue_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .ROM_ADDR_W(10), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_inst(out_inst2), .out_pc(out_pc2),
        .err_misaligned(err_misaligned2)
    );

    // ROM: word i holds 0x1000_0000 + i, one-cycle read latency
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= 32'h1000_0000 + {22'd0, imem_addr};
        if (imem_req2) imem_rdata2 <= 32'h1000_0000 + {22'd0, imem_addr2};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [9:0]  e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_err;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // rst rv rpc rdy | req addr valid pc inst err
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 10'h000, 1'b0, 32'h0,   32'h0,         1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h000, 1'b0, 32'h0,   32'h0,         1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h001, 1'b0, 32'h0,   32'h0,         1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h002, 1'b1, 32'h0,   32'h1000_0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h003, 1'b1, 32'h4,   32'h1000_0001, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 10'h004, 1'b1, 32'h8,   32'h1000_0002, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h080, 1'b0, 32'h0,   32'h0,         1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h081, 1'b0, 32'h0,   32'h0,         1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h082, 1'b1, 32'h200, 32'h1000_0080, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 10'h083, 1'b1, 32'h204, 32'h1000_0081, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h080, 1'b0, 32'h0,   32'h0,         1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h081, 1'b0, 32'h0,   32'h0,         1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h082, 1'b1, 32'h200, 32'h1000_0080, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 10'h083, 1'b1, 32'h204, 32'h1000_0081, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 10'h040, 1'b0, 32'h0,   32'h0,         1'b1};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h0C0, 1'b0, 32'h0,   32'h0,         1'b1};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h0C1, 1'b0, 32'h0,   32'h0,         1'b1};
        tbl[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 10'h0C2, 1'b1, 32'h300, 32'h1000_00C0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 10'h0C3, 1'b1, 32'h304, 32'h1000_00C1, 1'b1};

        // Table: reset state, streaming, redirects, misaligned flag
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].rdy;
            #1;
            $display("vec %0d: req=%b addr=%h valid=%b pc=%h inst=%h err=%b",
                     i, imem_req, imem_addr, out_valid, out_pc, out_inst, err_misaligned);
            chk($sformatf("v%0d imem_req", i),  32'(imem_req),       32'(tbl[i].e_req));
            chk($sformatf("v%0d imem_addr", i), 32'(imem_addr),      32'(tbl[i].e_addr));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid),      32'(tbl[i].e_valid));
            chk($sformatf("v%0d err", i),       32'(err_misaligned), 32'(tbl[i].e_err));
            if (tbl[i].e_valid || tbl[i].rst) begin
                chk($sformatf("v%0d out_pc", i),   out_pc,   tbl[i].e_pc);
                chk($sformatf("v%0d out_inst", i), out_inst, tbl[i].e_inst);
            end
        end

        // Backpressure from reset: exactly FIFO_DEPTH requests, then stall
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("bp rst err", 32'(err_misaligned), 32'd0);
        chk("bp rst valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int reqs;
            reqs = 0;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (imem_req) reqs++;
                $display("bp cycle %0d: req=%b addr=%h", c, imem_req, imem_addr);
                @(negedge clk);
            end
            chk("bp req count", 32'(reqs), 32'd4);
        end
        #1;
        chk("bp stalled req", 32'(imem_req), 32'd0);
        chk("bp fetch_pc addr", 32'(imem_addr), 32'h4);
        @(negedge clk);
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            $display("bp drain %0d: valid=%b pc=%h inst=%h", j, out_valid, out_pc, out_inst);
            chk($sformatf("drain%0d valid", j), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d pc", j), out_pc, 32'(4 * j));
            chk($sformatf("drain%0d inst", j), out_inst, 32'h1000_0000 + 32'(j));
            @(negedge clk);
        end

        // Fill FIFO, then async reset mid-cycle
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("full valid", 32'(out_valid), 32'd1);
        chk("full req", 32'(imem_req), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        $display("async rst: valid=%b req=%b pc=%h inst=%h", out_valid, imem_req, out_pc, out_inst);
        chk("arst valid", 32'(out_valid), 32'd0);
        chk("arst req", 32'(imem_req), 32'd0);
        chk("arst pc", out_pc, 32'd0);
        chk("arst inst", out_inst, 32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("restart c0 req", 32'(imem_req), 32'd1);
        chk("restart c0 addr", 32'(imem_addr), 32'd0);
        chk("restart c0 valid", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        chk("restart c1 valid", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        $display("restart c2: valid=%b pc=%h inst=%h", out_valid, out_pc, out_inst);
        chk("restart c2 valid", 32'(out_valid), 32'd1);
        chk("restart c2 pc", out_pc, 32'd0);
        chk("restart c2 inst", out_inst, 32'h1000_0000);

        // PC and imem_addr wrap-around on second instance
        @(negedge clk);
        rst2 = 1'b0;
        begin
            logic [9:0]  exp_addr [4];
            logic [31:0] exp_pc   [4];
            logic [31:0] exp_inst [4];
            exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
            exp_pc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
            exp_inst = '{32'h1000_03FE, 32'h1000_03FF, 32'h1000_0000, 32'h1000_0001};
            for (int c = 0; c < 6; c++) begin
                #1;
                $display("wrap cycle %0d: req=%b addr=%h valid=%b pc=%h inst=%h",
                         c, imem_req2, imem_addr2, out_valid2, out_pc2, out_inst2);
                if (c < 4) begin
                    chk($sformatf("wrap%0d addr", c), 32'(imem_addr2), 32'(exp_addr[c]));
                    chk($sformatf("wrap%0d req", c), 32'(imem_req2), 32'd1);
                end
                if (c >= 2) begin
                    chk($sformatf("wrap%0d valid", c), 32'(out_valid2), 32'd1);
                    chk($sformatf("wrap%0d pc", c), out_pc2, exp_pc[c-2]);
                    chk($sformatf("wrap%0d inst", c), out_inst2, exp_inst[c-2]);
                end
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
